// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter sharing one spi_master between NUM_REQ requesters.
// Optional watchdog on the WAIT state is built when SPI_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no transfer; pick next requester after the last owner
// START | owner granted, one-cycle start pulse to spi_master
// WAIT  | transfer in flight, waiting for done (or watchdog expiry)
// RESP  | one-cycle response pulse to owner, round-robin pointer advanced
module spi_rr_arbiter #(
    parameter int WIDTH          = 8,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     arb_busy,
    output logic                     m_start,
    output logic [WIDTH-1:0]         m_data_in,
    input  logic [WIDTH-1:0]         m_data_out,
    input  logic                     m_busy,
    input  logic                     m_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 arb_busy_q, arb_busy_d;
    logic                 m_start_q, m_start_d;
    logic [WIDTH-1:0]     m_data_in_q, m_data_in_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     own_q, own_d;

    logic [WIDTH-1:0]     req_word [NUM_REQ];
    logic                 win_valid;
    logic [IDX_W-1:0]     win_idx;

    // busy is informational only; sequencing relies on start/done
    logic                 unused_sig;
    assign unused_sig = m_busy ^ (TIMEOUT_CYCLES == 0);

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
`endif

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // Scan from farthest to nearest so the first hit after last_q is kept.
    always_comb begin
        int idx;
        idx       = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx[IDX_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = idx[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            arb_busy_q  <= 1'b0;
            m_start_q   <= 1'b0;
            m_data_in_q <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            own_q       <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            arb_busy_q  <= arb_busy_d;
            m_start_q   <= m_start_d;
            m_data_in_q <= m_data_in_d;
            last_q      <= last_d;
            own_q       <= own_d;
`ifdef SPI_ARB_TIMEOUT_EN
            tmr_q       <= tmr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        m_start_d   = 1'b0;
        m_data_in_d = m_data_in_q;
        last_d      = last_q;
        own_d       = own_q;
`ifdef SPI_ARB_TIMEOUT_EN
        tmr_d       = tmr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d     = NUM_REQ'(1) << win_idx;
                    own_d       = win_idx;
                    m_data_in_d = req_word[win_idx];
                    m_start_d   = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
`ifdef SPI_ARB_TIMEOUT_EN
                tmr_d   = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                state_d = WAIT;
            end
            WAIT: begin
                // done takes precedence over a watchdog expiry in the same cycle
                if (m_done) begin
                    rsp_data_d  = m_data_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = grant_q;
                    state_d     = RESP;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    rsp_data_d  = '1;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = grant_q;
                    state_d     = RESP;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`endif
            end
            RESP: begin
                grant_d = '0;
                last_d  = own_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        arb_busy_d = (state_d != IDLE);
    end

    assign grant     = grant_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign arb_busy  = arb_busy_q;
    assign m_start   = m_start_q;
    assign m_data_in = m_data_in_q;

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// Self-checking bench for spi_rr_arbiter; the bench plays both the requesters and the spi_master.
module tb_spi_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        arb_busy;
    logic        m_start;
    logic [7:0]  m_data_in;
    logic [7:0]  m_data_out;
    logic        m_busy;
    logic        m_done;

    int total = 0;
    int bad   = 0;
    int model_last;

    spi_rr_arbiter #(.WIDTH(8), .NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .arb_busy(arb_busy), .m_start(m_start), .m_data_in(m_data_in),
        .m_data_out(m_data_out), .m_busy(m_busy), .m_done(m_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first set bit strictly after 'last', wrapping.
    function automatic int pick(input logic [3:0] r, input int last);
        int i;
        for (int k = 1; k <= 4; k++) begin
            i = (last + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Acts as spi_master for one transfer and reports what it observed.
    task automatic serve_one(input logic [7:0] rx, input int dly, input int drop_bit, input bit scramble,
                             output int wc, output logic [3:0] g, output logic [7:0] tx,
                             output logic s0, output int starts, output logic [3:0] rv,
                             output logic [7:0] rd, output logic re, output bit to);
        wc = 0; g = '0; tx = '0; s0 = 1'b0; starts = 0; rv = '0; rd = '0; re = 1'b0; to = 1'b0;
        do begin
            tick();
            wc++;
        end while (grant == 4'b0 && wc < 20);
        if (grant == 4'b0) begin
            to = 1'b1;
            return;
        end
        g = grant; tx = m_data_in; s0 = m_start; starts = int'(m_start);
        if (scramble) req_data = $urandom;
        m_busy = 1'b1;
        tick();
        starts += int'(m_start);
        if (drop_bit >= 0) req[drop_bit] = 1'b0;
        repeat (dly) begin
            tick();
            starts += int'(m_start);
        end
        m_done = 1'b1; m_data_out = rx;
        tick();
        m_done = 1'b0; m_busy = 1'b0; m_data_out = 8'($urandom);
        rv = rsp_valid; rd = rsp_data; re = rsp_err;
        starts += int'(m_start);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_data = '0; m_data_out = '0; m_busy = 1'b0; m_done = 1'b0;
        repeat (3) tick();
        total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid); end
        total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data got=%h want=00", rsp_data); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
        total++; if (m_start !== 1'b0) begin bad++; $display("FAIL reset_m_start got=%b want=0", m_start); end
        total++; if (m_data_in !== 8'h00) begin bad++; $display("FAIL reset_m_data_in got=%h want=00", m_data_in); end
        total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL reset_arb_busy got=%b want=0", arb_busy); end
        rst = 1'b0;
        tick();
        total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL idle_no_req_busy got=%b want=0", arb_busy); end
        model_last = 3;
    endtask

    task automatic test_basic();
        int wc, st; logic [3:0] g, rv; logic [7:0] tx, rd; logic s0, re; bit to;
        req_data = $urandom;
        req_data[15:8] = 8'hA5;
        req = 4'b0010;
        serve_one(8'h3C, 3, -1, 1'b0, wc, g, tx, s0, st, rv, rd, re, to);
        total++; if (to || wc !== 1) begin bad++; $display("FAIL basic_grant_latency got=%0d want=1", wc); end
        total++; if (g !== 4'b0010) begin bad++; $display("FAIL basic_grant got=%b want=0010", g); end
        total++; if (tx !== 8'hA5) begin bad++; $display("FAIL basic_m_data_in got=%h want=a5", tx); end
        total++; if (s0 !== 1'b1 || st !== 1) begin bad++; $display("FAIL basic_start got=%b/%0d want=1/1", s0, st); end
        total++; if (rv !== 4'b0010) begin bad++; $display("FAIL basic_rsp_valid got=%b want=0010", rv); end
        total++; if (rd !== 8'h3C) begin bad++; $display("FAIL basic_rsp_data got=%h want=3c", rd); end
        total++; if (re !== 1'b0) begin bad++; $display("FAIL basic_rsp_err got=%b want=0", re); end
        req = 4'b0000;
        tick();
        total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL basic_pulse_width got=%b want=0000", rsp_valid); end
        total++; if (rsp_data !== 8'h3C) begin bad++; $display("FAIL basic_rsp_hold got=%h want=3c", rsp_data); end
        total++; if (grant !== 4'b0 || arb_busy !== 1'b0) begin bad++; $display("FAIL basic_release got=%b/%b want=0000/0", grant, arb_busy); end
        model_last = 1;
    endtask

    task automatic test_fairness();
        int wc, st, exp; logic [3:0] g, rv; logic [7:0] tx, rd, rx; logic s0, re; bit to;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        model_last = 3;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp = pick(req, model_last);
            rx = 8'($urandom);
            serve_one(rx, $urandom_range(0, 4), -1, 1'b0, wc, g, tx, s0, st, rv, rd, re, to);
            total++; if (to || g !== (4'b0001 << exp)) begin bad++; $display("FAIL fair_grant[%0d] got=%b want=%b", n, g, 4'b0001 << exp); end
            total++; if (tx !== 8'(8'h10 + exp)) begin bad++; $display("FAIL fair_m_data_in[%0d] got=%h want=%h", n, tx, 8'(8'h10 + exp)); end
            total++; if (s0 !== 1'b1 || st !== 1) begin bad++; $display("FAIL fair_start[%0d] got=%b/%0d want=1/1", n, s0, st); end
            total++; if (rv !== g || rd !== rx) begin bad++; $display("FAIL fair_rsp[%0d] got=%b/%h want=%b/%h", n, rv, rd, g, rx); end
            total++; if (wc !== ((n == 0) ? 1 : 2)) begin bad++; $display("FAIL fair_gap[%0d] got=%0d want=%0d", n, wc, (n == 0) ? 1 : 2); end
            model_last = exp;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_drop();
        int wc, st, exp; logic [3:0] g, rv; logic [7:0] tx, rd; logic s0, re; bit to;
        req_data = $urandom;
        req = 4'b1100;
        serve_one(8'h77, 3, 2, 1'b0, wc, g, tx, s0, st, rv, rd, re, to);
        total++; if (to || g !== 4'b0100) begin bad++; $display("FAIL drop_grant got=%b want=0100", g); end
        total++; if (rv !== 4'b0100 || rd !== 8'h77) begin bad++; $display("FAIL drop_rsp got=%b/%h want=0100/77", rv, rd); end
        model_last = 2;
        req = req | 4'b0010;
        exp = pick(req, model_last);
        serve_one(8'h88, 1, -1, 1'b0, wc, g, tx, s0, st, rv, rd, re, to);
        total++; if (to || g !== (4'b0001 << exp) || g !== 4'b1000) begin bad++; $display("FAIL drop_next_grant got=%b want=1000", g); end
        req = 4'b0000;
        tick();
        model_last = 3;
    endtask

    task automatic test_priority();
        int wc, st; logic [3:0] g, rv; logic [7:0] tx, rd; logic s0, re; bit to;
        req = 4'b0001;
        serve_one(8'h01, 0, -1, 1'b0, wc, g, tx, s0, st, rv, rd, re, to);
        total++; if (to || g !== 4'b0001) begin bad++; $display("FAIL prio_setup got=%b want=0001", g); end
        req = 4'b1001;
        serve_one(8'h02, 2, -1, 1'b0, wc, g, tx, s0, st, rv, rd, re, to);
        total++; if (to || g !== 4'b1000) begin bad++; $display("FAIL prio_first got=%b want=1000", g); end
        req[3] = 1'b0;
        serve_one(8'h03, 2, -1, 1'b0, wc, g, tx, s0, st, rv, rd, re, to);
        total++; if (to || g !== 4'b0001 || rv !== 4'b0001) begin bad++; $display("FAIL prio_second got=%b/%b want=0001/0001", g, rv); end
        req = 4'b0000;
        tick();
        model_last = 0;
    endtask

    task automatic test_random();
        int wc, st, exp, drop; logic [3:0] g, rv; logic [7:0] tx, rd, rx, exp_tx; logic s0, re; bit to;
        for (int n = 0; n < 20; n++) begin
            if (req == 4'b0) req = 4'($urandom_range(1, 15));
            req_data = $urandom;
            exp = pick(req, model_last);
            exp_tx = req_data[exp*8 +: 8];
            rx = 8'($urandom);
            drop = ($urandom_range(0, 1) == 1) ? exp : -1;
            serve_one(rx, $urandom_range(0, 6), drop, 1'b1, wc, g, tx, s0, st, rv, rd, re, to);
            total++; if (to || g !== (4'b0001 << exp)) begin bad++; $display("FAIL rand_grant[%0d] got=%b want=%b", n, g, 4'b0001 << exp); end
            total++; if (tx !== exp_tx) begin bad++; $display("FAIL rand_m_data_in[%0d] got=%h want=%h", n, tx, exp_tx); end
            total++; if (st !== 1 || rv !== g || rd !== rx || re !== 1'b0) begin bad++; $display("FAIL rand_rsp[%0d] got=%0d/%b/%h/%b want=1/%b/%h/0", n, st, rv, rd, re, g, rx); end
            total++; if (wc !== ((n == 0) ? 1 : 2)) begin bad++; $display("FAIL rand_gap[%0d] got=%0d want=%0d", n, wc, (n == 0) ? 1 : 2); end
            model_last = exp;
            req[exp] = 1'b0;
            req = req | (4'($urandom) & 4'($urandom));
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_in_wait();
        int wc, st, seen_rv, seen_busy; logic [3:0] g, rv; logic [7:0] tx, rd; logic s0, re; bit to;
        req = 4'b0001;
        tick(); tick();
        total++; if (arb_busy !== 1'b1 || grant !== 4'b0001) begin bad++; $display("FAIL rstw_in_wait got=%b/%b want=1/0001", arb_busy, grant); end
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b0000;
        total++; if (grant !== 4'b0 || m_start !== 1'b0 || arb_busy !== 1'b0 || rsp_valid !== 4'b0) begin
            bad++; $display("FAIL rstw_abort got=%b/%b/%b/%b want=0000/0/0/0", grant, m_start, arb_busy, rsp_valid);
        end
        model_last = 3;
        seen_rv = 0; seen_busy = 0;
        m_done = 1'b1; m_data_out = 8'hFF;
        tick();
        m_done = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (rsp_valid !== 4'b0) seen_rv++;
            if (arb_busy !== 1'b0) seen_busy++;
            tick();
        end
        total++; if (seen_rv !== 0 || seen_busy !== 0) begin bad++; $display("FAIL rstw_quiet got=%0d/%0d want=0/0", seen_rv, seen_busy); end
        req = 4'b1001;
        serve_one(8'h5E, 2, -1, 1'b0, wc, g, tx, s0, st, rv, rd, re, to);
        total++; if (to || g !== 4'b0001 || rv !== 4'b0001 || rd !== 8'h5E) begin bad++; $display("FAIL rstw_fresh got=%b/%b/%h want=0001/0001/5e", g, rv, rd); end
        req = 4'b0000;
        tick();
        model_last = 0;
    endtask

    task automatic test_timeout();
        int seen_rv, seen_err, k;
        req = 4'b0100;
        tick(); tick();
        m_done = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        k = 0;
        do begin
            tick();
            k++;
        end while (rsp_valid == 4'b0 && k < 40);
        total++; if (k !== 16) begin bad++; $display("FAIL timeout_latency got=%0d want=16", k); end
        total++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_data !== 8'hFF) begin
            bad++; $display("FAIL timeout_rsp got=%b/%b/%h want=0100/1/ff", rsp_valid, rsp_err, rsp_data);
        end
        seen_rv = 0; seen_err = 0;
`else
        seen_rv = 0; seen_err = 0; k = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (rsp_valid !== 4'b0) seen_rv++;
            if (rsp_err !== 1'b0) seen_err++;
        end
        total++; if (seen_rv !== 0 || seen_err !== 0) begin bad++; $display("FAIL no_timeout_quiet got=%0d/%0d want=0/0", seen_rv, seen_err); end
        total++; if (grant !== 4'b0100 || arb_busy !== 1'b1) begin bad++; $display("FAIL no_timeout_hold got=%b/%b want=0100/1", grant, arb_busy); end
        m_done = 1'b1; m_data_out = 8'h5A;
        tick();
        m_done = 1'b0;
        total++; if (rsp_valid !== 4'b0100 || rsp_data !== 8'h5A || rsp_err !== 1'b0) begin
            bad++; $display("FAIL no_timeout_done got=%b/%h/%b want=0100/5a/0", rsp_valid, rsp_data, rsp_err);
        end
`endif
        req = 4'b0000;
        tick();
        model_last = 2;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fairness();
        test_drop();
        test_priority();
        test_random();
        test_reset_in_wait();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
